// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for arithmetic_and_memory_unit. It owns the PC and
// steps each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB.
module datapath_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [2:0]  flags,
  input  logic [31:0] address,
  output logic [31:0] PCout,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        DataPCSel,
  output logic        RegSelect,
  output logic [2:0]  ALUop,
  output logic [1:0]  ALUinSel,
  output logic        busy,
  output logic        halted,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RALU = 6'd0;
  localparam logic [5:0] OP_IALU = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_ST   = 6'd3;
  localparam logic [5:0] OP_BZ   = 6'd4;
  localparam logic [5:0] OP_BR   = 6'd5;
  localparam logic [5:0] OP_CALL = 6'd6;
  localparam logic [5:0] OP_HALT = 6'h3f;

  // The MEM down-counter starts at MEM_WAIT-1 so the enable is high MEM_WAIT cycles.
  localparam logic [3:0] MEM_WAIT_CNT = 4'(MEM_WAIT - 1);

  state_t      state;
  logic [5:0]  op_q;
  logic [3:0]  wait_cnt;
  logic [31:0] pc_seq;
  logic        unused_flags;

  assign pc_seq       = PCout + 32'd1;
  // Carry and sign are not consumed by any current branch condition.
  assign unused_flags = ^flags[2:1];

  // NOTE: every state and output register uses <= so all of them update together
  // from the values present before the edge; the async reset clears them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      PCout       <= RESET_PC;
      instr_count <= '0;
      op_q        <= '0;
      wait_cnt    <= '0;
      RegWrite    <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      MemtoReg    <= 1'b0;
      DataPCSel   <= 1'b0;
      RegSelect   <= 1'b0;
      ALUop       <= '0;
      ALUinSel    <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          op_q <= opcode;
          if (opcode == OP_HALT || opcode > OP_CALL) begin
            state      <= S_HALT;
            busy       <= 1'b0;
            halted     <= 1'b1;
            illegal_op <= (opcode != OP_HALT);
          end else begin
            // ALU controls are loaded here and held until the instruction retires.
            state    <= S_EXEC;
            MemtoReg <= (opcode == OP_RALU) || (opcode == OP_IALU) || (opcode == OP_CALL);
            unique case (opcode)
              OP_RALU:      begin ALUop <= 3'b001; ALUinSel <= 2'b00; end
              OP_IALU:      begin ALUop <= 3'b001; ALUinSel <= 2'b10; end
              OP_LD, OP_ST: begin ALUop <= 3'b000; ALUinSel <= 2'b10; end
              OP_BZ:        begin ALUop <= 3'b010; ALUinSel <= 2'b01; end
              default:      begin ALUop <= 3'b000; ALUinSel <= 2'b00; end
            endcase
          end
        end

        S_EXEC: begin
          unique case (op_q)
            OP_LD: begin
              state    <= S_MEM;
              MemRead  <= 1'b1;
              wait_cnt <= MEM_WAIT_CNT;
            end
            OP_ST: begin
              state    <= S_MEM;
              MemWrite <= 1'b1;
              wait_cnt <= MEM_WAIT_CNT;
            end
            OP_BZ, OP_BR: begin
              // Flags are sampled on the edge that leaves EXEC.
              state       <= S_FETCH;
              ALUop       <= '0;
              ALUinSel    <= '0;
              MemtoReg    <= 1'b0;
              instr_count <= instr_count + 32'd1;
              PCout       <= (op_q == OP_BR || flags[0]) ? address : pc_seq;
            end
            default: begin
              state     <= S_WB;
              RegWrite  <= 1'b1;
              RegSelect <= (op_q == OP_CALL);
              DataPCSel <= (op_q == OP_CALL);
            end
          endcase
        end

        S_MEM: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            if (op_q == OP_LD) begin
              state    <= S_WB;
              RegWrite <= 1'b1;
            end else begin
              state       <= S_FETCH;
              ALUop       <= '0;
              ALUinSel    <= '0;
              MemtoReg    <= 1'b0;
              instr_count <= instr_count + 32'd1;
              PCout       <= pc_seq;
            end
          end
        end

        S_WB: begin
          state       <= S_FETCH;
          RegWrite    <= 1'b0;
          RegSelect   <= 1'b0;
          DataPCSel   <= 1'b0;
          ALUop       <= '0;
          ALUinSel    <= '0;
          MemtoReg    <= 1'b0;
          instr_count <= instr_count + 32'd1;
          PCout       <= (op_q == OP_CALL) ? address : pc_seq;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: an ISA-level model of a small program
// memory predicts every retirement and halt; a negedge monitor compares them.
module tb_datapath_sequencer;

  localparam int          MEM_WAIT = 3;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int          IMEM     = 64;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  opcode;
  logic [2:0]  flags;
  logic [31:0] address;
  logic [31:0] PCout, instr_count;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect;
  logic [2:0]  ALUop;
  logic [1:0]  ALUinSel;
  logic        busy, halted, illegal_op;

  logic [5:0]  imem_op    [IMEM];
  logic [31:0] imem_addr  [IMEM];
  logic [2:0]  imem_flags [IMEM];

  // The "datapath": instruction fields and flags follow the current PC.
  assign opcode  = imem_op[PCout[5:0]];
  assign address = imem_addr[PCout[5:0]];
  assign flags   = imem_flags[PCout[5:0]];

  always #5 clk = ~clk;

  datapath_sequencer #(.RESET_PC(RESET_PC), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .flags(flags),
    .address(address), .PCout(PCout), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .DataPCSel(DataPCSel),
    .RegSelect(RegSelect), .ALUop(ALUop), .ALUinSel(ALUinSel), .busy(busy),
    .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  typedef struct {
    bit          is_halt;
    bit          illegal;
    logic [31:0] pc;
    logic [31:0] count;
    bit          alu_care;
    logic [2:0]  aluop;
    logic [1:0]  alusel;
    bit          mtr_care;
    bit          mtr;
    int          rw;
    bit          rs;
    bit          dps;
    int          rd;
    int          wr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: execute the program from RESET_PC and record what each
  // instruction must look like when it retires.
  task automatic run_model(input int max_n);
    logic [31:0] pc = RESET_PC;
    logic [5:0]  op;
    int          n  = 0;
    exp_t        e;
    exp_q.delete();
    forever begin
      op = imem_op[pc[5:0]];
      e  = '{default: 0};
      if (op == 6'h3f || op > 6'd6) begin
        e.is_halt = 1'b1;
        e.illegal = (op != 6'h3f);
        e.pc      = pc;
        e.count   = n;
        exp_q.push_back(e);
        break;
      end
      case (op)
        6'd0: begin e.alu_care = 1; e.aluop = 3'b001; e.alusel = 2'b00; e.mtr_care = 1; e.mtr = 1; e.rw = 1; end
        6'd1: begin e.alu_care = 1; e.aluop = 3'b001; e.alusel = 2'b10; e.mtr_care = 1; e.mtr = 1; e.rw = 1; end
        6'd2: begin e.alu_care = 1; e.aluop = 3'b000; e.alusel = 2'b10; e.mtr_care = 1; e.mtr = 0; e.rw = 1; e.rd = MEM_WAIT; end
        6'd3: begin e.alu_care = 1; e.aluop = 3'b000; e.alusel = 2'b10; e.wr = MEM_WAIT; end
        6'd4: begin e.alu_care = 1; e.aluop = 3'b010; e.alusel = 2'b01; end
        6'd6: begin e.rw = 1; e.rs = 1; e.dps = 1; end
        default: ;
      endcase
      case (op)
        6'd4:       pc = imem_flags[pc[5:0]][0] ? imem_addr[pc[5:0]] : pc + 32'd1;
        6'd5, 6'd6: pc = imem_addr[pc[5:0]];
        default:    pc = pc + 32'd1;
      endcase
      n++;
      e.pc    = pc;
      e.count = n;
      exp_q.push_back(e);
      if (n == max_n) break;
    end
  endtask

  // Monitor: sample on the falling edge; a change of instr_count marks a retirement
  // whose last cycle is the previous sample.
  logic [31:0] last_count;
  logic        last_halted;
  int          rd_n, wr_n, rw_n;
  logic [2:0]  p_aluop;
  logic [1:0]  p_alusel;
  logic        p_mtr, p_rs, p_dps;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!reset) begin
      last_count  = '0;
      last_halted = 1'b0;
      rd_n = 0; wr_n = 0; rw_n = 0;
    end else begin
      if (MemRead || MemWrite) check("mem_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
      if (instr_count != last_count) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_retire: got count %0d with nothing expected", instr_count);
        end else begin
          m_e = exp_q.pop_front();
          check("retire_not_halt", {31'd0, m_e.is_halt}, 32'd0);
          check("retire_pc", PCout, m_e.pc);
          check("retire_count", instr_count, m_e.count);
          if (m_e.alu_care) begin
            check("retire_aluop", {29'd0, p_aluop}, {29'd0, m_e.aluop});
            check("retire_aluinsel", {30'd0, p_alusel}, {30'd0, m_e.alusel});
          end
          if (m_e.mtr_care) check("retire_memtoreg", {31'd0, p_mtr}, {31'd0, m_e.mtr});
          check("regwrite_cycles", rw_n, m_e.rw);
          check("regselect", {31'd0, p_rs}, {31'd0, m_e.rs});
          check("datapcsel", {31'd0, p_dps}, {31'd0, m_e.dps});
          check("memread_cycles", rd_n, m_e.rd);
          check("memwrite_cycles", wr_n, m_e.wr);
        end
        rd_n = 0; wr_n = 0; rw_n = 0;
      end
      if (halted && !last_halted) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_halt: got halted=1 with nothing expected");
        end else begin
          m_e = exp_q.pop_front();
          check("halt_expected", 32'd1, {31'd0, m_e.is_halt});
          check("halt_illegal_op", {31'd0, illegal_op}, {31'd0, m_e.illegal});
          check("halt_busy", {31'd0, busy}, 32'd0);
          check("halt_count", instr_count, m_e.count);
          check("halt_pc", PCout, m_e.pc);
        end
      end
      rd_n += int'(MemRead);
      wr_n += int'(MemWrite);
      rw_n += int'(RegWrite);
      p_aluop     = ALUop;
      p_alusel    = ALUinSel;
      p_mtr       = MemtoReg;
      p_rs        = RegSelect;
      p_dps       = DataPCSel;
      last_count  = instr_count;
      last_halted = halted;
    end
  end

  task automatic clear_imem();
    for (int i = 0; i < IMEM; i++) begin
      imem_op[i]    = 6'h3f;
      imem_addr[i]  = '0;
      imem_flags[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    checks++; failures++;
    $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic run_prog(input string name, input int max_n);
    do_reset();
    run_model(max_n);
    pulse_start();
    wait_drain(name, 3000);
  endtask

  int lat;
  int r;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    clear_imem();
    #12;
    check("rst_pc", PCout, RESET_PC);
    check("rst_count", instr_count, 32'd0);
    check("rst_ctrl", {RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, ALUop, ALUinSel}, 32'd0);
    check("rst_status", {busy, halted, illegal_op}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // R-ALU then HALT; WB is the fourth cycle after the edge that samples start.
    clear_imem();
    imem_op[0] = 6'd0;
    run_model(8);
    pulse_start();
    lat = 1;
    while (!RegWrite && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rw_latency", lat, 4);
    wait_drain("ralu", 100);

    // LD: MemRead for MEM_WAIT cycles then a WB with MemtoReg=0.
    clear_imem();
    imem_op[0] = 6'd2;
    run_prog("ld", 8);

    // BZ at PC=5 to 20, taken and not taken.
    for (int t = 0; t < 2; t++) begin
      clear_imem();
      for (int i = 0; i < 5; i++) imem_op[i] = 6'd0;
      imem_op[5]    = 6'd4;
      imem_addr[5]  = 32'd20;
      imem_flags[5] = (t == 0) ? 3'b001 : 3'b110;
      run_prog("bz", 16);
    end

    // CALL at PC=7 to 40.
    clear_imem();
    for (int i = 0; i < 7; i++) imem_op[i] = 6'd1;
    imem_op[7]   = 6'd6;
    imem_addr[7] = 32'd40;
    run_prog("call", 16);

    // Undefined opcode halts; later start pulses are ignored.
    clear_imem();
    imem_op[0] = 6'b001111;
    run_prog("illegal", 4);
    pulse_start();
    repeat (4) @(negedge clk);
    check("halt_sticky", {29'd0, halted, busy, illegal_op}, 32'b101);
    check("halt_count_hold", instr_count, 32'd0);

    // Reset in the middle of a ST's MEM phase.
    clear_imem();
    imem_op[0] = 6'd3;
    do_reset();
    run_model(4);
    pulse_start();
    lat = 0;
    while (!MemWrite && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("st_reached_mem", {31'd0, MemWrite}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_memwrite", {31'd0, MemWrite}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_pc", PCout, RESET_PC);
    check("post_rst_idle", {30'd0, busy, RegWrite}, 32'd0);

    // Random programs.
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < IMEM; i++) begin
        r = $urandom_range(0, 19);
        if (r < 17)       imem_op[i] = 6'(r % 7);
        else if (r < 19)  imem_op[i] = 6'h3f;
        else              imem_op[i] = 6'($urandom_range(7, 62));
        imem_addr[i]  = 32'($urandom_range(0, IMEM - 1));
        imem_flags[i] = 3'($urandom_range(0, 7));
      end
      run_prog("random", 30);
    end

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
